aes_key_expand: RTL and testbench
=================================

Name: aes_key_expand

Overview:
- AES-128 key schedule controller; sits directly upstream of the SubWord unit and consumes its result.
- Takes a 128-bit cipher key and produces round keys 0..10 one at a time.
- For each round it applies RotWord to the last word, sends the word to SubWord over a req/done handshake, applies Rcon, and forms the next four words.
- Round keys feed the round datapath through a valid/ready interface.

Parameters:
- SW_TIMEOUT, 15: maximum cycles to wait for sw_done after sw_req before flagging an error.
- RCON_INIT, 8'h01: Rcon value for round 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches key_in and begins expansion; accepted only in IDLE or DONE.
- key_in  in  128  cipher key, word w0 = key_in[127:96].
- sw_req  out  1  one-cycle pulse requesting substitution of sw_word.
- sw_word  out  32  RotWord(w3) = {w3[23:0], w3[31:24]}; held stable from sw_req until sw_done.
- sw_done  in  1  SubWord result valid, for one cycle.
- sw_result  in  32  substituted word, sampled when sw_done=1.
- round_key  out  128  current round key, {w4r, w4r+1, w4r+2, w4r+3}.
- rk_index  out  4  round number of round_key, 0..10.
- rk_valid  out  1  round_key/rk_index valid.
- rk_ready  in  1  consumer accepts the round key when rk_valid && rk_ready.
- busy  out  1  high from start acceptance until the last handshake.
- done  out  1  high in DONE state.
- sw_err  out  1  sticky; set on SubWord timeout and cleared by reset or start.

Behaviour:
- Reset values:
  - sw_req, rk_valid, busy, done, sw_err = 0.
  - round_key, sw_word = 0; rk_index = 0.
  - Rcon = RCON_INIT; state = IDLE.
- States: IDLE, LOAD, EMIT, SUB_REQ, SUB_WAIT, COMBINE, DONE, ERR.
- IDLE/DONE: on start, latch key_in into w[0..3], rk_index=0, Rcon=RCON_INIT, clear sw_err, busy=1, done=0, then go to LOAD.
- LOAD: 1 cycle; round_key = key; go to EMIT.
- EMIT:
  - rk_valid=1; round_key and rk_index must stay stable while rk_valid && !rk_ready.
  - On handshake: if rk_index==10, go to DONE (busy=0, done=1); otherwise go to SUB_REQ.
- SUB_REQ: drive sw_word = RotWord(w3), pulse sw_req for 1 cycle, clear the timeout counter, go to SUB_WAIT.
- SUB_WAIT:
  - On sw_done: capture t = sw_result ^ {Rcon, 24'h0} and go to COMBINE.
  - Otherwise increment the counter; when it reaches SW_TIMEOUT, set sw_err, drop busy, go to ERR.
- COMBINE: 1 cycle.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - rk_index += 1.
  - Rcon = xtime(Rcon), i.e. {Rcon[6:0],1'b0} ^ (Rcon[7] ? 8'h1B : 0), so 0x80 becomes 0x1B.
  - Go to EMIT.
- ERR: outputs idle, sw_err=1; only start or reset leaves.
- Latency:
  - start to first rk_valid = 2 cycles.
  - Per subsequent round: 1 (SUB_REQ) + L (SubWord latency, sw_done L cycles after sw_req, L≥1) + 1 (COMBINE) cycles after the preceding handshake.
- Boundary conditions:
  - start while busy: ignored.
  - sw_done outside SUB_WAIT: ignored.
  - sw_done in the same cycle the timeout count is reached: sw_done wins.
  - Reset mid-expansion: abort immediately to reset values; a stray sw_done after reset is ignored.
  - rk_ready held low indefinitely: block stalls in EMIT with no timeout.
  - Rcon sequence: 01,02,04,08,10,20,40,80,1B,36.

Optional Feature:
- KEYEXP_STORE_EN.
- When defined: an 11x128 internal key store, written at each EMIT entry, plus ports rd_idx (in, 4) and rd_key (out, 128). rd_key is the registered store[rd_idx], 1-cycle latency.
  - rd_idx > 10 returns 0.
  - Reads of rounds not yet written return 0; the store is cleared on reset and on start.
- When undefined: the ports and storage do not exist; behaviour is otherwise identical.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, SubWord model L=4, rk_ready=1 -> rk_index 0 = key; rk 1 = a0fafe1788542cb123a339392a6c7605; rk 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done=1 after 11 handshakes.
- Same key, rk_ready toggled pseudo-randomly -> identical key sequence; round_key stable while stalled; exactly 11 handshakes.
- First sw_req -> sw_word = 09cf4f3c rotated = cf4f3c09; with sw_result 8a84eb01 -> t = 8b84eb01 (Rcon 01).
- SubWord model never asserts sw_done -> sw_err=1, busy=0 after SW_TIMEOUT+1 cycles in SUB_WAIT; a new start clears sw_err and expansion completes.
- reset asserted during round 5 SUB_WAIT, late sw_done arrives -> all outputs return to reset values, no rk_valid; a subsequent start of key 000102030405060708090a0b0c0d0e0f gives rk 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- KEYEXP_STORE_EN: after the FIPS key completes, rd_idx=1 -> rd_key = a0fafe17...7605 one cycle later; rd_idx=12 -> 0.

Source files
------------

// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - AES-128 key schedule controller driving an external SubWord unit.
// Define KEYEXP_STORE_EN to add an 11-entry round key store readable via rd_idx/rd_key.
module aes_key_expand #(
  parameter int          SW_TIMEOUT = 15,
  parameter logic [7:0]  RCON_INIT  = 8'h01
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         sw_req,
  output logic [31:0]  sw_word,
  input  logic         sw_done,
  input  logic [31:0]  sw_result,
  output logic [127:0] round_key,
  output logic [3:0]   rk_index,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done,
`ifdef KEYEXP_STORE_EN
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key,
`endif
  output logic         sw_err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_EMIT     = 3'd2;
  localparam logic [2:0] S_SUB_REQ  = 3'd3;
  localparam logic [2:0] S_SUB_WAIT = 3'd4;
  localparam logic [2:0] S_COMBINE  = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;
  localparam logic [2:0] S_ERR      = 3'd7;

  localparam int            CW     = (SW_TIMEOUT < 1) ? 1 : $clog2(SW_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(SW_TIMEOUT);

  logic [2:0]    state;
  logic [31:0]   w0, w1, w2, w3;
  logic [31:0]   t;
  logic [7:0]    rcon;
  logic [CW-1:0] cnt;
  logic [31:0]   n0, n1, n2, n3;
  logic          start_acc;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  // Next four words chain off each other, so the whole round is one XOR ripple.
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign start_acc = start && (state == S_IDLE || state == S_DONE || state == S_ERR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      w0        <= '0;
      w1        <= '0;
      w2        <= '0;
      w3        <= '0;
      t         <= '0;
      rcon      <= RCON_INIT;
      cnt       <= '0;
      sw_req    <= 1'b0;
      sw_word   <= '0;
      round_key <= '0;
      rk_index  <= '0;
      rk_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sw_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_acc) begin
            w0       <= key_in[127:96];
            w1       <= key_in[95:64];
            w2       <= key_in[63:32];
            w3       <= key_in[31:0];
            rk_index <= '0;
            rcon     <= RCON_INIT;
            sw_err   <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          round_key <= {w0, w1, w2, w3};
          rk_valid  <= 1'b1;
          state     <= S_EMIT;
        end
        S_EMIT: begin
          // No timeout here: a stalled consumer simply holds the key.
          if (rk_ready) begin
            rk_valid <= 1'b0;
            if (rk_index == 4'd10) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              sw_req  <= 1'b1;
              sw_word <= {w3[23:0], w3[31:24]};
              state   <= S_SUB_REQ;
            end
          end
        end
        S_SUB_REQ: begin
          sw_req <= 1'b0;
          cnt    <= '0;
          state  <= S_SUB_WAIT;
        end
        S_SUB_WAIT: begin
          // A result arriving on the timeout cycle is still taken.
          if (sw_done) begin
            t     <= sw_result ^ {rcon, 24'h0};
            state <= S_COMBINE;
          end else if (cnt == TO_MAX) begin
            sw_err <= 1'b1;
            busy   <= 1'b0;
            state  <= S_ERR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_COMBINE: begin
          w0        <= n0;
          w1        <= n1;
          w2        <= n2;
          w3        <= n3;
          round_key <= {n0, n1, n2, n3};
          rk_index  <= rk_index + 4'd1;
          rcon      <= xtime(rcon);
          rk_valid  <= 1'b1;
          state     <= S_EMIT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef KEYEXP_STORE_EN
  logic [127:0] store [0:10];

  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      for (int i = 0; i < 11; i++) store[i] <= '0;
    end else if (state == S_LOAD) begin
      store[0] <= {w0, w1, w2, w3};
    end else if (state == S_COMBINE) begin
      store[rk_index + 4'd1] <= {n0, n1, n2, n3};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_key <= '0;
    end else begin
      rd_key <= (rd_idx <= 4'd10) ? store[rd_idx] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// tb/tb_aes_key_expand.sv - directed bench for aes_key_expand with an S-box based SubWord model.
// Exercises the KEYEXP_STORE_EN read port when that macro is defined.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         reset, start, sw_req, sw_done, rk_valid, rk_ready, busy, done, sw_err;
  logic [127:0] key_in, round_key;
  logic [31:0]  sw_word, sw_result;
  logic [3:0]   rk_index;
`ifdef KEYEXP_STORE_EN
  logic [3:0]   rd_idx = 4'd0;
  logic [127:0] rd_key;
`endif

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk(clk), .reset(reset), .start(start), .key_in(key_in),
    .sw_req(sw_req), .sw_word(sw_word), .sw_done(sw_done), .sw_result(sw_result),
    .round_key(round_key), .rk_index(rk_index), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .busy(busy), .done(done),
`ifdef KEYEXP_STORE_EN
    .rd_idx(rd_idx), .rd_key(rd_key),
`endif
    .sw_err(sw_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY2     = 128'h000102030405060708090a0b0c0d0e0f;

  logic [127:0] fips [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic [2047:0] sbox_tab = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] subword(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      int b;
      b = int'(x[i*8 +: 8]);
      r[i*8 +: 8] = sbox_tab[(255 - b)*8 +: 8];
    end
    return r;
  endfunction

  // SubWord model: answers sw_req after sw_lat cycles unless muted; ignores reset on purpose.
  int          sw_lat  = 4;
  bit          sw_mute = 1'b0;
  int          pend    = 0;
  logic [31:0] pend_word;

  initial begin
    sw_done   = 1'b0;
    sw_result = '0;
  end

  always @(negedge clk) begin
    sw_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        sw_done   = 1'b1;
        sw_result = subword(pend_word);
      end
    end
    if (sw_req && !sw_mute) begin
      pend      = sw_lat;
      pend_word = sw_word;
    end
  end

  int           hs_cnt;
  logic [127:0] last_rk;
  logic [31:0]  first_sw;

  task automatic run_exp(input logic [127:0] key, input bit rnd, input bit full,
                         input bit inj, input int abort_at);
    bit           finished = 1'b0;
    bit           got_sw = 1'b0;
    bit           injected = 1'b0;
    bit           stall_prev = 1'b0;
    logic [127:0] prev_key = '0;
    logic [3:0]   prev_idx = '0;
    hs_cnt   = 0;
    last_rk  = '0;
    first_sw = '0;
    @(negedge clk);
    key_in   = key;
    start    = 1'b1;
    rk_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("load_busy", 128'(busy), 128'(1));
    chk("load_valid", 128'(rk_valid), 128'(0));
    chk("start_clr_err", 128'(sw_err), 128'(0));
    @(negedge clk);
    chk("lat_valid", 128'(rk_valid), 128'(1));
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (done) begin
        finished = 1'b1;
        break;
      end
      if (abort_at >= 0 && sw_req && hs_cnt == abort_at) return;
      start  = 1'b0;
      key_in = key;
      if (inj && !injected && hs_cnt == 3) begin
        start    = 1'b1;
        key_in   = '0;
        injected = 1'b1;
      end
      if (sw_req && !got_sw) begin
        first_sw = sw_word;
        got_sw   = 1'b1;
      end
      if (stall_prev) begin
        chk("stall_valid", 128'(rk_valid), 128'(1));
        chk("stall_key", round_key, prev_key);
        chk("stall_idx", 128'(rk_index), 128'(prev_idx));
      end
      rk_ready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stall_prev = rk_valid && !rk_ready;
      prev_key   = round_key;
      prev_idx   = rk_index;
      if (rk_valid && rk_ready) begin
        chk("rk_idx", 128'(rk_index), 128'(hs_cnt));
        if (full && hs_cnt <= 10) chk($sformatf("rk%0d", hs_cnt), round_key, fips[hs_cnt]);
        if (hs_cnt == 0) chk("rk0_key", round_key, key);
        last_rk = round_key;
        hs_cnt++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!finished) chk("exp_timeout", 128'(0), 128'(1));
  endtask

  task automatic chk_end(input string tag);
    chk({tag, "_hs"}, 128'(hs_cnt), 128'(11));
    chk({tag, "_done"}, 128'(done), 128'(1));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_valid"}, 128'(rk_valid), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    key_in   = '0;
    rk_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_flags", 128'({sw_req, rk_valid, busy, done, sw_err}), 128'(0));
    chk("rst_round_key", round_key, 128'(0));
    chk("rst_sw_word", 128'(sw_word), 128'(0));
    chk("rst_rk_index", 128'(rk_index), 128'(0));

    // FIPS-197 key, always-ready consumer, with a start pulse injected mid-run.
    run_exp(FIPS_KEY, 1'b0, 1'b1, 1'b1, -1);
    chk_end("fips");
    chk("first_sw_word", 128'(first_sw), 128'(32'hcf4f3c09));
    chk("fips_rk10", last_rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

`ifdef KEYEXP_STORE_EN
    rd_idx = 4'd1;
    @(negedge clk);
    chk("store_rd1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
    rd_idx = 4'd12;
    @(negedge clk);
    chk("store_rd12", rd_key, 128'(0));
    rd_idx = 4'd10;
    @(negedge clk);
    chk("store_rd10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_idx = 4'd0;
`endif

    // Same key with a randomly stalling consumer.
    run_exp(FIPS_KEY, 1'b1, 1'b1, 1'b0, -1);
    chk_end("rand");

    // SubWord never answers: timeout after SW_TIMEOUT+1 cycles in SUB_WAIT.
    sw_mute = 1'b1;
    run_exp(FIPS_KEY, 1'b0, 1'b1, 1'b0, 1);
    repeat (16) @(negedge clk);
    chk("to_err_early", 128'(sw_err), 128'(0));
    chk("to_busy_early", 128'(busy), 128'(1));
    @(negedge clk);
    chk("to_err", 128'(sw_err), 128'(1));
    chk("to_busy", 128'(busy), 128'(0));
    chk("to_idle", 128'({rk_valid, done, sw_req}), 128'(0));
    sw_mute = 1'b0;
    run_exp(FIPS_KEY, 1'b0, 1'b1, 1'b0, -1);
    chk_end("after_to");
    chk("after_to_err", 128'(sw_err), 128'(0));

    // Reset during round 5 SUB_WAIT; the model's late sw_done must be ignored.
    run_exp(FIPS_KEY, 1'b0, 1'b1, 1'b0, 5);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("post_rst_flags", 128'({sw_req, rk_valid, busy, done, sw_err}), 128'(0));
      @(negedge clk);
    end
    chk("post_rst_key", round_key, 128'(0));
    chk("post_rst_idx", 128'(rk_index), 128'(0));
    chk("post_rst_sw_word", 128'(sw_word), 128'(0));

    run_exp(KEY2, 1'b0, 1'b0, 1'b0, -1);
    chk_end("key2");
    chk("key2_rk10", last_rk, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
